vram_line_writer: RTL

//  Write-side front end for the dual-port line VRAM: sole driver of VRAM port A.

---
 rtl/vram_line_writer_pkg.sv | 12 +
 rtl/vram_line_writer.sv | 86 ++++++++
 2 files changed

// File: rtl/vram_line_writer_pkg.sv
// vram_line_writer_pkg: frame geometry and FSM states shared by the VRAM writer and the VGA reader.
package vram_line_writer_pkg;
    localparam int LINE_W = 640;
    localparam int ROWS   = 480;
    localparam int ADDR_W = 9;
    localparam int BEAT_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int BCNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
    typedef enum logic [1:0] {S_FILL, S_WRITE, S_CLEAR} state_t;
endpackage

// File: rtl/vram_line_writer.sv
// vram_line_writer: packs a 1bpp beat stream into VRAM lines on port A and runs full-screen clears.
module vram_line_writer
    import vram_line_writer_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [BEAT_W-1:0] pix_data,
    input  logic              clear_req,
    input  logic              clear_val,
    output logic              busy,
    output logic              frame_done,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [LINE_W-1:0] vram_din
);
    state_t            state, state_nxt;
    logic [BCNT_W-1:0] beat_cnt, beat_idx;
    logic [ADDR_W-1:0] row, row_idx;
    logic [LINE_W-1:0] line, line_nxt;
    logic              accept, start_clear, last_beat, clear_end;
    always_comb begin
        pix_ready   = (state == S_FILL) && !clear_req && clr_n;
        start_clear = (state == S_FILL) && clear_req;
        accept      = pix_valid && pix_ready;
        beat_idx    = pix_sof ? '0 : beat_cnt;
        row_idx     = pix_sof ? '0 : row;
        last_beat   = accept && (beat_idx == LAST_BEAT);
        clear_end   = (state == S_CLEAR) && (row == LAST_ROW);
        line_nxt    = line;
        line_nxt[beat_idx*BEAT_W +: BEAT_W] = pix_data;
        state_nxt   = start_clear ? S_CLEAR :
                      last_beat ? S_WRITE :
                      (state == S_WRITE || clear_end) ? S_FILL : state;
    end
    always_ff @(posedge clk) begin
        if (!clr_n)
            state <= S_FILL;
        else
            state <= state_nxt;
    end
    // Port A outputs are registered; during a clear vram_din itself holds the latched fill colour.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            beat_cnt   <= '0;
            row        <= '0;
            line       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_din   <= '0;
        end else begin
            vram_we    <= 1'b0;
            frame_done <= 1'b0;
            if (start_clear) begin
                busy      <= 1'b1;
                vram_we   <= 1'b1;
                vram_addr <= '0;
                vram_din  <= {LINE_W{clear_val}};
                row       <= '0;
            end else if (accept) begin
                line       <= line_nxt;
                beat_cnt   <= last_beat ? '0 : beat_idx + 1'b1;
                row        <= row_idx;
                vram_we    <= last_beat;
                vram_addr  <= row_idx;
                vram_din   <= line_nxt;
                frame_done <= last_beat && (row_idx == LAST_ROW);
            end else if (state == S_WRITE) begin
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else if (clear_end) begin
                busy     <= 1'b0;
                row      <= '0;
                beat_cnt <= '0;
                line     <= '0;
            end else if (state == S_CLEAR) begin
                vram_we   <= 1'b1;
                row       <= row + 1'b1;
                vram_addr <= row + 1'b1;
            end
        end
    end
endmodule
